// File: rtl/par_ser_pkg.sv
// Shared types and helpers for the parallel/serial link: FSM states,
// bit-counter sizing and frame-length arithmetic.
package par_ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int bitcnt_width(input int data_w);
        return (data_w > 2) ? $clog2(data_w) : 1;
    endfunction

    function automatic int frame_cycles(input int data_w, input int div);
        return data_w * 2 * div;
    endfunction

    localparam int DEF_DATA_W = 8;
    localparam int BITCNT_W   = bitcnt_width(DEF_DATA_W);

endpackage

// File: rtl/ser_clk_gen.sv
// Bit-clock generator: divides CLK_IN by 2*DIV while enabled and flags the
// edge on which SER_CLK is about to rise or fall.
module ser_clk_gen
    import par_ser_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLK_IN,
    input  logic RST,
    input  logic en,
    output logic ser_clk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PH_W-1:0] phase;
    logic            toggle;

    assign toggle    = en && (phase == PH_W'(DIV - 1));
    assign rise_tick = toggle && !ser_clk;
    assign fall_tick = toggle && ser_clk;

    // Disabling parks the divider so every frame starts from phase 0, SER_CLK low.
    always_ff @(posedge CLK_IN) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST || !en) begin
            phase   <= '0;
            ser_clk <= 1'b0;
        end else if (toggle) begin
            phase   <= '0;
            ser_clk <= ~ser_clk;
        end else begin
            phase   <= phase + PH_W'(1);
        end
    end

endmodule

// File: rtl/par_to_ser_tx.sv
// Parallel-to-serial transmitter: accepts a word on LOAD/READY and shifts it
// out on SER_OUT, qualified by FRAME and clocked out on SER_CLK.
module par_to_ser_tx
    import par_ser_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              CLK_IN,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              LOAD,
    output logic              READY,
    output logic              SER_OUT,
    output logic              SER_CLK,
    output logic              FRAME,
    output logic              DONE
);

    localparam int CNT_W = bitcnt_width(DATA_W);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt, shreg_adv;
    logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
    logic              ser_out_q, ser_out_nxt;
    logic              frame_q, frame_nxt;
    logic              ready_q, ready_nxt;
    logic              done_q, done_nxt;
    logic              fall_tick;
    logic              unused_rise_tick;  // data only moves on falling ticks

    ser_clk_gen #(
        .DIV       (DIV)
    ) u_ser_clk_gen (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .en        (state == SHIFT),
        .ser_clk   (SER_CLK),
        .rise_tick (unused_rise_tick),
        .fall_tick (fall_tick)
    );

    // The bit on SER_OUT is always the leading end of the shift register.
    assign shreg_adv = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                        : {1'b0, shreg[DATA_W-1:1]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt   = state;
        shreg_nxt   = shreg;
        bitcnt_nxt  = bitcnt;
        ser_out_nxt = ser_out_q;
        frame_nxt   = frame_q;
        ready_nxt   = ready_q;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (LOAD && ready_q) begin
                    state_nxt   = SHIFT;
                    shreg_nxt   = DIN;
                    bitcnt_nxt  = '0;
                    ser_out_nxt = (MSB_FIRST != 0) ? DIN[DATA_W-1] : DIN[0];
                    frame_nxt   = 1'b1;
                    ready_nxt   = 1'b0;
                end
            end
            SHIFT: begin
                if (fall_tick) begin
                    if (bitcnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt   = IDLE;
                        ser_out_nxt = 1'b0;
                        frame_nxt   = 1'b0;
                        ready_nxt   = 1'b1;
                        done_nxt    = 1'b1;
                    end else begin
                        bitcnt_nxt  = bitcnt + CNT_W'(1);
                        shreg_nxt   = shreg_adv;
                        ser_out_nxt = (MSB_FIRST != 0) ? shreg_adv[DATA_W-1] : shreg_adv[0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            ser_out_q <= 1'b0;
            frame_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bitcnt    <= bitcnt_nxt;
            ser_out_q <= ser_out_nxt;
            frame_q   <= frame_nxt;
            ready_q   <= ready_nxt;
            done_q    <= done_nxt;
        end
    end

    assign READY   = ready_q;
    assign SER_OUT = ser_out_q;
    assign FRAME   = frame_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Bench for par_to_ser_tx: four instances with different DIV / bit orders,
// observed by a loopback receiver model that samples on SER_CLK rising edges.
module tb_par_to_ser_tx;
    import par_ser_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] din [4];
    logic [3:0] load   = '0;
    logic [3:0] ready, ser_out, ser_clk, frame, done;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        par_to_ser_tx #(
            .DATA_W    (8),
            .DIV       ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4),
            .MSB_FIRST ((g == 0 || g == 2) ? 1 : 0)
        ) u_dut (
            .CLK_IN  (clk_in),
            .RST     (rst),
            .DIN     (din[g]),
            .LOAD    (load[g]),
            .READY   (ready[g]),
            .SER_OUT (ser_out[g]),
            .SER_CLK (ser_clk[g]),
            .FRAME   (frame[g]),
            .DONE    (done[g])
        );
    end

    function automatic int div_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit msb_of(input int g);
        return (g == 0 || g == 2);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- loopback receiver / protocol monitor ----------------
    logic [7:0] arrival  [4] = '{default: '0};
    logic [7:0] last_arr [4] = '{default: '0};
    logic [7:0] rx_hist  [4][16];
    int n_rx        [4] = '{default: 0};
    int aborted     [4] = '{default: 0};
    int frame_cnt   [4] = '{default: 0};
    int last_len    [4] = '{default: 0};
    int rises       [4] = '{default: 0};
    int last_rises  [4] = '{default: 0};
    int since_rise  [4] = '{default: 0};
    int gap_cnt     [4] = '{default: 0};
    int last_gap    [4] = '{default: 0};
    int done_cnt    [4] = '{default: 0};
    int rise_change [4] = '{default: 0};
    int hold_bad    [4] = '{default: 0};
    int done_rdy_bad[4] = '{default: 0};
    int ready_bad   [4] = '{default: 0};
    logic [3:0] prev_clk = '0, prev_out = '0, prev_frame = '0;

    task automatic monitor_step();
        for (int g = 0; g < 4; g++) begin
            since_rise[g]++;
            if (frame[g]) frame_cnt[g]++;
            if (frame[g] && !prev_frame[g]) last_gap[g] = gap_cnt[g];
            if (ser_clk[g] && !prev_clk[g]) begin
                if (ser_out[g] !== prev_out[g]) rise_change[g]++;
                if (frame[g]) begin
                    if (rises[g] > 0 && since_rise[g] != 2 * div_of(g)) hold_bad[g]++;
                    arrival[g] = {arrival[g][6:0], ser_out[g]};
                    rises[g]++;
                end
                since_rise[g] = 0;
            end
            if (done[g]) begin
                done_cnt[g]++;
                if (!ready[g]) done_rdy_bad[g]++;
            end
            if (frame[g] && ready[g]) ready_bad[g]++;
            if (!frame[g] && prev_frame[g]) begin
                last_len[g]   = frame_cnt[g];
                last_rises[g] = rises[g];
                if (rises[g] == 8) begin
                    last_arr[g] = arrival[g];
                    rx_hist[g][n_rx[g] % 16] = msb_of(g) ? arrival[g] : rev8(arrival[g]);
                    n_rx[g]++;
                end else begin
                    aborted[g]++;
                end
                frame_cnt[g] = 0;
                rises[g]     = 0;
                gap_cnt[g]   = 0;
            end
            if (!frame[g]) gap_cnt[g]++;
            prev_clk[g]   = ser_clk[g];
            prev_out[g]   = ser_out[g];
            prev_frame[g] = frame[g];
        end
    endtask

    initial forever begin
        @(negedge clk_in);
        monitor_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic wait_ready(input int g);
        int n = 0;
        while (!ready[g] && n < 500) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(ready[g]), 32'd1);
    endtask

    task automatic wait_rx(input int g, input int target);
        int n = 0;
        int budget = frame_cycles(8, div_of(g)) + 40;
        while (n_rx[g] < target && n < budget) begin
            tick();
            n++;
        end
        check("rx_timeout", 32'(n_rx[g] >= target), 32'd1);
    endtask

    task automatic send_pulse(input int g, input logic [7:0] w);
        wait_ready(g);
        din[g]  = w;
        load[g] = 1'b1;
        tick();
        load[g] = 1'b0;
        din[g]  = 8'($urandom);
    endtask

    typedef struct {
        int         g;
        logic [7:0] din;
        logic [7:0] arrival;
        int         len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_rx, base_done;
        logic [7:0] w;

        for (int g = 0; g < 4; g++) din[g] = '0;

        vecs[0] = '{g: 0, din: 8'hA5, arrival: 8'hA5, len: 16};
        vecs[1] = '{g: 1, din: 8'h01, arrival: 8'h80, len: 48};
        vecs[2] = '{g: 2, din: 8'h3C, arrival: 8'h3C, len: 32};
        vecs[3] = '{g: 3, din: 8'h12, arrival: 8'h48, len: 64};
        vecs[4] = '{g: 1, din: 8'hF0, arrival: 8'h0F, len: 48};
        vecs[5] = '{g: 3, din: 8'h0E, arrival: 8'h70, len: 64};

        // Reset state
        tick();
        tick();
        check("rst_ready",   32'(ready),   32'hF);
        check("rst_ser_out", 32'(ser_out), 32'h0);
        check("rst_ser_clk", 32'(ser_clk), 32'h0);
        check("rst_frame",   32'(frame),   32'h0);
        check("rst_done",    32'(done),    32'h0);
        rst = 1'b0;
        tick();

        // Table-driven single frames
        foreach (vecs[i]) begin
            base_rx   = n_rx[vecs[i].g];
            base_done = done_cnt[vecs[i].g];
            send_pulse(vecs[i].g, vecs[i].din);
            wait_rx(vecs[i].g, base_rx + 1);
            check($sformatf("v%0d_bits", i),  32'(last_arr[vecs[i].g]), 32'(vecs[i].arrival));
            check($sformatf("v%0d_word", i),  32'(rx_hist[vecs[i].g][base_rx % 16]), 32'(vecs[i].din));
            check($sformatf("v%0d_flen", i),  32'(last_len[vecs[i].g]), 32'(vecs[i].len));
            check($sformatf("v%0d_rises", i), 32'(last_rises[vecs[i].g]), 32'd8);
            check($sformatf("v%0d_dones", i), 32'(done_cnt[vecs[i].g] - base_done), 32'd1);
        end

        // Back-to-back with LOAD held high
        wait_ready(2);
        base_rx   = n_rx[2];
        base_done = done_cnt[2];
        din[2]  = 8'h3C;
        load[2] = 1'b1;
        tick();
        din[2] = 8'hC3;
        wait_rx(2, base_rx + 1);
        tick();
        load[2] = 1'b0;
        din[2]  = 8'h00;
        check("b2b_gap", 32'(last_gap[2]), 32'd1);
        wait_rx(2, base_rx + 2);
        check("b2b_word0", 32'(rx_hist[2][base_rx % 16]), 32'h3C);
        check("b2b_word1", 32'(rx_hist[2][(base_rx + 1) % 16]), 32'hC3);
        check("b2b_dones", 32'(done_cnt[2] - base_done), 32'd2);
        for (int i = 0; i < 6; i++) tick();
        check("b2b_idle", 32'(frame[2]), 32'd0);

        // LOAD while busy is ignored
        base_rx   = n_rx[0];
        base_done = done_cnt[0];
        send_pulse(0, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        din[0]  = 8'hFF;
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        wait_rx(0, base_rx + 1);
        check("busy_word", 32'(rx_hist[0][base_rx % 16]), 32'h00);
        check("busy_flen", 32'(last_len[0]), 32'd16);
        for (int i = 0; i < 5; i++) tick();
        check("busy_dones", 32'(done_cnt[0] - base_done), 32'd1);
        check("busy_frame", 32'(frame[0]), 32'd0);

        // Reset during bit 4
        base_rx   = n_rx[0];
        base_done = done_cnt[0];
        send_pulse(0, 8'hFF);
        for (int i = 0; i < 8; i++) tick();
        check("pre_rst_ser_out", 32'(ser_out[0]), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_ser_out", 32'(ser_out[0]), 32'd0);
        check("abort_ser_clk", 32'(ser_clk[0]), 32'd0);
        check("abort_frame",   32'(frame[0]),   32'd0);
        check("abort_ready",   32'(ready[0]),   32'd1);
        check("abort_done",    32'(done[0]),    32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_done", 32'(done_cnt[0] - base_done), 32'd0);
        check("abort_no_rx",   32'(n_rx[0] - base_rx), 32'd0);
        send_pulse(0, 8'h5A);
        wait_rx(0, base_rx + 1);
        check("after_rst_word", 32'(rx_hist[0][base_rx % 16]), 32'h5A);

        // Randomised loopback on DIV 1, 2 and 4
        for (int i = 0; i < 30; i++) begin
            int g;
            g = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 3;
            w = 8'($urandom);
            base_rx = n_rx[g];
            send_pulse(g, w);
            wait_rx(g, base_rx + 1);
            check($sformatf("rnd%0d_word", i), 32'(rx_hist[g][base_rx % 16]), 32'(w));
            check($sformatf("rnd%0d_flen", i), 32'(last_len[g]), 32'(16 * div_of(g)));
        end

        // Whole-run protocol properties
        for (int g = 0; g < 4; g++) begin
            check($sformatf("d%0d_rise_change", g), 32'(rise_change[g]), 32'd0);
            check($sformatf("d%0d_bit_hold", g),    32'(hold_bad[g]),    32'd0);
            check($sformatf("d%0d_done_ready", g),  32'(done_rdy_bad[g]), 32'd0);
            check($sformatf("d%0d_ready_busy", g),  32'(ready_bad[g]),   32'd0);
            check($sformatf("d%0d_done_vs_rx", g),  32'(done_cnt[g]),    32'(n_rx[g]));
        end
        check("aborted_frames", 32'(aborted[0] + aborted[1] + aborted[2] + aborted[3]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
